// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit_if
// Brief    : Address/offset bus between the PC unit and the branch-offset table.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_pc_unit_if;
    logic [5:0] lut_addr;
    logic [3:0] lut_val;

    // The PC unit requests; the table answers combinationally.
    modport master (output lut_addr, input  lut_val);
    modport slave  (input  lut_addr, output lut_val);
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit
// Brief    : Program counter and branch sequencer with one-bubble table lookup.
// Revision : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             halt,
    input  wire logic             stall_in,
    input  wire logic             br_req,
    input  wire logic [1:0]       br_type,
    input  wire logic             zero_flag,
    input  wire logic [5:0]       br_idx,
    branch_pc_unit_if.master      lut,
    output logic      [PC_W-1:0]  pc,
    output logic                  pc_valid,
    output logic                  redirect,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LOOKUP = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] C_BR_BZ   = 2'b01;
    localparam logic [1:0] C_BR_BNZ  = 2'b10;
    localparam logic [1:0] C_BR_JUMP = 2'b11;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [5:0]      lut_addr_q, lut_addr_d;
    logic            pc_valid_q, pc_valid_d;
    logic            redirect_q, redirect_d;
    logic            done_q, done_d;

    logic            w_taken;
    logic [PC_W-1:0] w_offset;

    assign w_taken = br_req & ((br_type == C_BR_JUMP) |
                               ((br_type == C_BR_BZ)  &  zero_flag) |
                               ((br_type == C_BR_BNZ) & ~zero_flag));

    // Table offset is 4-bit two's complement; widen to PC width.
    assign w_offset = {{(PC_W-4){lut.lut_val[3]}}, lut.lut_val};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        lut_addr_d = lut_addr_q;
        pc_valid_d = pc_valid_q;
        redirect_d = 1'b0;
        done_d     = done_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d    = S_RUN;
                    pc_d       = START_PC;
                    pc_valid_d = 1'b1;
                    done_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (stall_in) begin
                    state_d = S_RUN;
                end else if (halt) begin
                    state_d    = S_HALTED;
                    done_d     = 1'b1;
                    pc_valid_d = 1'b0;
                end else if (w_taken) begin
                    state_d    = S_LOOKUP;
                    lut_addr_d = br_idx;
                    pc_valid_d = 1'b0;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            S_LOOKUP: begin
                state_d    = S_RUN;
                pc_d       = pc_q + PC_W'(1) + w_offset;
                pc_valid_d = 1'b1;
                redirect_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= START_PC;
            lut_addr_q <= '0;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lut_addr_q <= lut_addr_d;
            pc_valid_q <= pc_valid_d;
            redirect_q <= redirect_d;
            done_q     <= done_d;
        end
    end

    assign lut.lut_addr = lut_addr_q;
    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign redirect     = redirect_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Program counter and branch sequencer for the core fetch path. It is the requesting end of the branch-offset lookup table. It drives the 6-bit lookup address, samples the 4-bit offset returned combinationally, and redirects the PC. It also handles start, halt, stall and the conditional-branch decision (bz/bnz/jump).

Parameters:
PC_W, 8, program counter width in bits; PC arithmetic is modulo 2^PC_W.
START_PC, 0, PC value loaded on start.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin or restart execution; honoured in IDLE and HALTED only
halt  input  1  halt request from decode, sampled in RUN
stall_in  input  1  external stall; freezes RUN
br_req  input  1  current instruction is a branch or jump
br_type  input  2  branch kind: 00 none, 01 bz, 10 bnz, 11 jump
zero_flag  input  1  ALU zero flag for the current instruction
br_idx  input  6  lookup-table index carried by the branch instruction
lut_addr  output  6  registered address to the offset lookup table
lut_val  input  4  signed two's-complement offset returned by the table, combinational from lut_addr
pc  output  PC_W  current program counter
pc_valid  output  1  pc is a valid fetch address this cycle
redirect  output  1  one-cycle pulse; pc was just loaded from a branch target (flush fetch)
done  output  1  processor halted

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pc=START_PC, lut_addr=0, pc_valid=0, redirect=0, done=0.
  - Reset asserted in any state, including LOOKUP, forces these values immediately.
- All outputs are registered.
- States: IDLE, RUN, LOOKUP, HALTED.
- IDLE:
  - pc held.
  - start=1 -> RUN; pc<=START_PC; pc_valid<=1.
- RUN, stall_in=1: every register holds. halt, br_req and start are ignored that cycle.
- RUN, stall_in=0: priority is halt > taken branch > sequential.
  - taken = br_req & ((br_type==11) | (br_type==01 & zero_flag) | (br_type==10 & !zero_flag)).
  - br_type 00 is never taken.
  - halt=1: -> HALTED; done<=1; pc_valid<=0; pc held.
  - taken: -> LOOKUP; lut_addr<=br_idx; pc_valid<=0; pc held.
  - otherwise: pc<=pc+1 (wraps at 2^PC_W-1 to 0).
  - start is ignored in RUN.
- LOOKUP (exactly one cycle; stall_in, halt and start are ignored):
  - pc<=pc+1+sext(lut_val) mod 2^PC_W.
  - pc_valid<=1; redirect<=1; -> RUN.
- redirect is 1 only in the first RUN cycle after LOOKUP, otherwise 0.
- lut_addr holds its last value outside the taken-branch load.
- Branch timing: taken branch at pc=P, accepted at edge k.
  - Cycle after k: pc=P, pc_valid=0, lut_addr=br_idx.
  - After edge k+1: pc=target, pc_valid=1, redirect=1.
  - Taken-branch penalty is 1 bubble.
- HALTED:
  - done stays 1; pc held; pc_valid=0.
  - start=1 -> RUN; pc<=START_PC; done<=0; pc_valid<=1.
- Offset range: lut_val 4'h8..4'hF gives -8..-1; 4'h0..4'h7 gives 0..+7.
  - Target range is pc-7..pc+8, wrapping modulo 2^PC_W.
  - lut_val=4'hF (-1) targets pc itself (legal self-loop).
- A back-to-back taken branch in the first RUN cycle after redirect is legal and enters LOOKUP again.

Test Plan:
- Reset, then start pulse -> pc=0x00 with pc_valid=1 on the next cycle, then 0x01, 0x02, 0x03 on successive cycles; redirect=0, done=0.
- At pc=0x03: br_req=1, br_type=01, zero_flag=1, br_idx=6'h05, table returns 4'hE -> lut_addr=0x05 and pc_valid=0 for one cycle; then pc=0x02, redirect=1 for one cycle, then pc=0x03.
- At pc=0x10: br_type=10 with zero_flag=1 -> not taken, pc=0x11, no bubble. Same with zero_flag=0 and lut_val=4'h3 -> pc=0x14 after one bubble.
- Jump at pc=0xFC (PC_W=8) with lut_val=4'h7 -> pc=0x04 (wrap), redirect=1. Sequential run from 0xFF -> 0x00.
- halt=1 and a taken jump in the same RUN cycle at pc=0x20 -> done=1, pc stays 0x20, pc_valid=0, lut_addr unchanged. Then start -> pc=0x00, done=0.
- stall_in=1 for 3 cycles during a pending taken branch in RUN -> pc and state frozen; branch taken only once stall_in drops.
- Reset asserted during LOOKUP -> immediately pc=0, pc_valid=0, redirect=0, IDLE.
